// File: rtl/varredor_triangulo.sv
// varredor_triangulo: raster scan sequencer for a point-in-triangle tester.
// Latches three vertices, walks every integer point of their bounding box in
// row-major order, and streams the points the tester flags as inside through
// a single-entry valid/ready output register, then reports the inside count.
module varredor_triangulo (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  xa,
    input  logic [9:0]  ya,
    input  logic [9:0]  xb,
    input  logic [9:0]  yb,
    input  logic [9:0]  xc,
    input  logic [9:0]  yc,
    output logic [9:0]  px,
    output logic [9:0]  py,
    input  logic        s_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_x,
    output logic [9:0]  out_y,
    output logic        busy,
    output logic        done,
    output logic [20:0] count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BBOX,
        S_SCAN,
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  xa_q, ya_q, xb_q, yb_q, xc_q, yc_q;
    logic [9:0]  xa_d, ya_d, xb_d, yb_d, xc_d, yc_d;
    logic [9:0]  xmin_q, xmax_q, ymax_q;
    logic [9:0]  xmin_d, xmax_d, ymax_d;
    logic [9:0]  px_q, py_q, px_d, py_d;
    logic        outValid_q, outValid_d;
    logic [9:0]  outX_q, outY_q, outX_d, outY_d;
    logic [20:0] count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        regFree;
    logic        drain;
    logic        lastPoint;

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    assign regFree   = !outValid_q || out_ready;
    assign drain     = outValid_q && out_ready;
    assign lastPoint = (px_q == xmax_q) && (py_q == ymax_q);

    // Next-state logic: vertex latch, bounding box, scan walk, output register and count.
    always_comb begin
        state_d    = state_q;
        xa_d       = xa_q;
        ya_d       = ya_q;
        xb_d       = xb_q;
        yb_d       = yb_q;
        xc_d       = xc_q;
        yc_d       = yc_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymax_d     = ymax_q;
        px_d       = px_q;
        py_d       = py_q;
        outValid_d = outValid_q;
        outX_d     = outX_q;
        outY_d     = outY_q;
        count_d    = count_q;

        if (drain) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xa_d       = xa;
                    ya_d       = ya;
                    xb_d       = xb;
                    yb_d       = yb;
                    xc_d       = xc;
                    yc_d       = yc;
                    count_d    = 21'd0;
                    outValid_d = 1'b0;
                    outX_d     = 10'd0;
                    outY_d     = 10'd0;
                    state_d    = S_BBOX;
                end
            end
            S_BBOX: begin
                xmin_d  = min3(xa_q, xb_q, xc_q);
                xmax_d  = max3(xa_q, xb_q, xc_q);
                ymax_d  = max3(ya_q, yb_q, yc_q);
                px_d    = min3(xa_q, xb_q, xc_q);
                py_d    = min3(ya_q, yb_q, yc_q);
                state_d = S_SCAN;
            end
            S_SCAN: begin
                // An inside point that cannot be stored freezes the walk; otherwise advance.
                if (!(s_in && !regFree)) begin
                    if (s_in) begin
                        outValid_d = 1'b1;
                        outX_d     = px_q;
                        outY_d     = py_q;
                        count_d    = count_q + 21'd1;
                    end
                    if (lastPoint) begin
                        state_d = S_FINISH;
                    end else if (px_q == xmax_q) begin
                        px_d = xmin_q;
                        py_d = py_q + 10'd1;
                    end else begin
                        px_d = px_q + 10'd1;
                    end
                end
            end
            S_FINISH: begin
                if (!outValid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH) && !outValid_d;
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            xa_q       <= 10'd0;
            ya_q       <= 10'd0;
            xb_q       <= 10'd0;
            yb_q       <= 10'd0;
            xc_q       <= 10'd0;
            yc_q       <= 10'd0;
            xmin_q     <= 10'd0;
            xmax_q     <= 10'd0;
            ymax_q     <= 10'd0;
            px_q       <= 10'd0;
            py_q       <= 10'd0;
            outValid_q <= 1'b0;
            outX_q     <= 10'd0;
            outY_q     <= 10'd0;
            count_q    <= 21'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xa_q       <= xa_d;
            ya_q       <= ya_d;
            xb_q       <= xb_d;
            yb_q       <= yb_d;
            xc_q       <= xc_d;
            yc_q       <= yc_d;
            xmin_q     <= xmin_d;
            xmax_q     <= xmax_d;
            ymax_q     <= ymax_d;
            px_q       <= px_d;
            py_q       <= py_d;
            outValid_q <= outValid_d;
            outX_q     <= outX_d;
            outY_q     <= outY_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign px        = px_q;
    assign py        = py_q;
    assign out_valid = outValid_q;
    assign out_x     = outX_q;
    assign out_y     = outY_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
